// File: rtl/window_gen_3x3_if.sv
// window_gen_3x3_if: pixel-in / window-out handshake bundle.
// slave is the generator's view, master the driver/consumer view.
interface window_gen_3x3_if #(
   parameter int IMG_W = 64,
   parameter int IMG_H = 64
);
   localparam int RW = $clog2(IMG_H);
   localparam int KW = $clog2(IMG_W);

   logic          i_in_valid;
   logic          o_in_ready;
   logic [7:0]    i_pixel;
   logic          o_win_valid;
   logic          i_win_ready;
   logic [7:0]    o_p00, o_p01, o_p02;
   logic [7:0]    o_p10, o_p11, o_p12;
   logic [7:0]    o_p20, o_p21, o_p22;
   logic [RW-1:0] o_row;
   logic [KW-1:0] o_col;
   logic          o_frame_done;

   modport slave (
      input  i_in_valid, i_pixel, i_win_ready,
      output o_in_ready, o_win_valid,
      output o_p00, o_p01, o_p02,
      output o_p10, o_p11, o_p12,
      output o_p20, o_p21, o_p22,
      output o_row, o_col, o_frame_done
   );

   modport master (
      output i_in_valid, i_pixel, i_win_ready,
      input  o_in_ready, o_win_valid,
      input  o_p00, o_p01, o_p02,
      input  o_p10, o_p11, o_p12,
      input  o_p20, o_p21, o_p22,
      input  o_row, o_col, o_frame_done
   );
endinterface

// File: rtl/window_gen_3x3.sv
// window_gen_3x3: raster pixel stream to 3x3 windows with border padding.
// Define WINGEN_REPLICATE_PAD_EN to clamp border taps instead of zeroing.
module window_gen_3x3 #(
   parameter int IMG_W = 64,
   parameter int IMG_H = 64
) (
   input logic             i_clk,
   input logic             i_rst_n,
   window_gen_3x3_if.slave bus
);
   localparam int N   = IMG_W * IMG_H;
   localparam int CW  = $clog2(N + 1);
   localparam int RW  = $clog2(IMG_H);
   localparam int KW  = $clog2(IMG_W);
   localparam int SRL = 2 * IMG_W + 3;
   localparam int AW  = $clog2(SRL);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FILL  = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;
   localparam logic [1:0] ST_FLUSH = 2'd3;

   logic [CW-1:0] n_in, n_in_d, n_out, n_out_d;
   logic [RW-1:0] row_q, row_d;
   logic [KW-1:0] col_q, col_d;
   logic [1:0]    state_q, state_d;
   logic          valid_q, valid_d;
   logic          done_q, done_d;
   logic          in_ready, in_acc, out_acc;
   logic [7:0]    sr [SRL];
   logic [7:0]    sr_n [SRL];
   logic [7:0]    win_q [9];
   logic [7:0]    win_d [9];

   assign in_ready = (state_q != ST_FLUSH) &&
                     (int'(n_in) < int'(n_out) + IMG_W + 2);
   assign in_acc   = bus.i_in_valid & in_ready;
   assign out_acc  = valid_q & bus.i_win_ready;

   always_comb begin
      int lim;
      n_in_d  = n_in + CW'(in_acc);
      n_out_d = n_out + CW'(out_acc);
      row_d   = row_q;
      col_d   = col_q;
      done_d  = 1'b0;
      if (out_acc) begin
         if (int'(col_q) == IMG_W - 1) begin
            col_d = '0;
            row_d = row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
      if (int'(n_out_d) == N) begin
         done_d  = 1'b1;
         n_in_d  = '0;
         n_out_d = '0;
         row_d   = '0;
         col_d   = '0;
      end
      state_d = ST_RUN;
      unique case (1'b1)
         (n_in_d == '0):                  state_d = ST_IDLE;
         (n_in_d != '0 &&
          int'(n_in_d) < IMG_W + 2):      state_d = ST_FILL;
         (int'(n_in_d) == N):             state_d = ST_FLUSH;
         (int'(n_in_d) >= IMG_W + 2 &&
          int'(n_in_d) < N):              state_d = ST_RUN;
      endcase
      // window is eligible once its bottom-right tap has arrived
      lim = int'(n_out_d) + IMG_W + 2;
      if (lim > N) lim = N;
      valid_d = (int'(n_out_d) < N) && (int'(n_in_d) >= lim);
   end

   always_comb begin
      for (int i = 0; i < SRL; i++) sr_n[i] = sr[i];
      if (in_acc) begin
         sr_n[0] = bus.i_pixel;
         for (int i = 1; i < SRL; i++) sr_n[i] = sr[i-1];
      end
   end

   // sr_n[0] is the newest pixel; a tap's age is its raster distance from it
   always_comb begin
      int kr, kc, d, rr, cc, age;
      logic pad;
      kr = int'(row_d);
      kc = int'(col_d);
      d  = int'(n_in_d) - int'(n_out_d);
      rr = 0;
      cc = 0;
      age = 0;
      pad = 1'b0;
      for (int t = 0; t < 9; t++) begin
         rr  = kr + t / 3 - 1;
         cc  = kc + t % 3 - 1;
         pad = 1'b0;
`ifdef WINGEN_REPLICATE_PAD_EN
         if (rr < 0) rr = 0;
         if (rr > IMG_H - 1) rr = IMG_H - 1;
         if (cc < 0) cc = 0;
         if (cc > IMG_W - 1) cc = IMG_W - 1;
`else
         pad = (rr < 0) || (rr > IMG_H - 1) ||
               (cc < 0) || (cc > IMG_W - 1);
`endif
         age = d - 1 - ((rr - kr) * IMG_W + (cc - kc));
         win_d[t] = '0;
         if (!pad && age >= 0 && age < SRL)
            win_d[t] = sr_n[age[AW-1:0]];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         n_in    <= '0;
         n_out   <= '0;
         row_q   <= '0;
         col_q   <= '0;
         state_q <= ST_IDLE;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         for (int t = 0; t < 9; t++) win_q[t] <= '0;
      end else begin
         n_in    <= n_in_d;
         n_out   <= n_out_d;
         row_q   <= row_d;
         col_q   <= col_d;
         state_q <= state_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         if (valid_d)
            for (int t = 0; t < 9; t++) win_q[t] <= win_d[t];
      end
   end

   always_ff @(posedge i_clk) begin
      if (in_acc) sr <= sr_n;
   end

   assign bus.o_in_ready   = in_ready;
   assign bus.o_win_valid  = valid_q;
   assign bus.o_frame_done = done_q;
   assign bus.o_row        = row_q;
   assign bus.o_col        = col_q;
   assign bus.o_p00 = win_q[0];
   assign bus.o_p01 = win_q[1];
   assign bus.o_p02 = win_q[2];
   assign bus.o_p10 = win_q[3];
   assign bus.o_p11 = win_q[4];
   assign bus.o_p12 = win_q[5];
   assign bus.o_p20 = win_q[6];
   assign bus.o_p21 = win_q[7];
   assign bus.o_p22 = win_q[8];
endmodule

// File: tb/tb_window_gen_3x3.sv
// tb_window_gen_3x3: directed and gapped-stream checks on a 4x4 image.
// Expectations follow WINGEN_REPLICATE_PAD_EN when it is defined.
module tb_window_gen_3x3;
   localparam int W = 4;
   localparam int H = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   window_gen_3x3_if #(.IMG_W(W), .IMG_H(H)) bus();
   window_gen_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic [7:0] src [64];
   int nsrc, pix_idx;
   logic [71:0] cap_win [$];
   int cap_row [$];
   int cap_col [$];
   int cap_cyc [$];
   int done_cnt, done_cyc, acc6_cyc, first_vcyc;
   logic rdy_at16;
   bit seen16;

   function automatic logic [71:0] win_now();
      return {bus.o_p00, bus.o_p01, bus.o_p02,
              bus.o_p10, bus.o_p11, bus.o_p12,
              bus.o_p20, bus.o_p21, bus.o_p22};
   endfunction

   function automatic logic [71:0] gold(input int base, input int k);
      logic [71:0] w;
      logic [7:0] v;
      int r, c, rr, cc;
      w = '0;
      r = k / W;
      c = k % W;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
`ifdef WINGEN_REPLICATE_PAD_EN
            rr = (rr < 0) ? 0 : (rr > H - 1) ? H - 1 : rr;
            cc = (cc < 0) ? 0 : (cc > W - 1) ? W - 1 : cc;
            v = src[base + rr * W + cc];
`else
            if (rr < 0 || rr >= H || cc < 0 || cc >= W) v = 8'd0;
            else v = src[base + rr * W + cc];
`endif
            w = {w[63:0], v};
         end
      end
      return w;
   endfunction

   task automatic clear_caps();
      cap_win.delete();
      cap_row.delete();
      cap_col.delete();
      cap_cyc.delete();
      done_cnt = 0;
      done_cyc = -1;
      acc6_cyc = -1;
      first_vcyc = -1;
      seen16 = 1'b0;
      rdy_at16 = 1'bx;
      pix_idx = 0;
   endtask

   task automatic step(input bit iv, input bit wr);
      bus.i_in_valid  = iv && (pix_idx < nsrc);
      bus.i_pixel     = (pix_idx < nsrc) ? src[pix_idx] : 8'd0;
      bus.i_win_ready = wr;
      if (bus.o_win_valid && first_vcyc < 0) first_vcyc = cyc;
      if (bus.o_frame_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (!seen16 && pix_idx == 16) begin
         seen16 = 1'b1;
         rdy_at16 = bus.o_in_ready;
      end
      if (bus.i_in_valid && bus.o_in_ready) begin
         if (pix_idx == 5) acc6_cyc = cyc;
         pix_idx++;
      end
      if (bus.o_win_valid && wr) begin
         cap_win.push_back(win_now());
         cap_row.push_back(int'(bus.o_row));
         cap_col.push_back(int'(bus.o_col));
         cap_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      bus.i_in_valid = 1'b0;
      bus.i_pixel = 8'd0;
      bus.i_win_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.o_win_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_valid: got %b want 0", bus.o_win_valid);
      end
      checks++;
      if (bus.o_frame_done !== 1'b0) begin
         errors++;
         $display("FAIL rst_done: got %b want 0", bus.o_frame_done);
      end
      checks++;
      if (win_now() !== 72'd0) begin
         errors++;
         $display("FAIL rst_win: got %h want 0", win_now());
      end
      checks++;
      if (bus.o_row !== '0 || bus.o_col !== '0) begin
         errors++;
         $display("FAIL rst_rc: got %0d,%0d want 0,0", bus.o_row, bus.o_col);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      checks++;
      if (bus.o_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_ready: got %b want 1", bus.o_in_ready);
      end
   endtask

   task automatic test_stream();
      logic [71:0] e00, e11, e33;
`ifdef WINGEN_REPLICATE_PAD_EN
      e00 = {8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd4, 8'd4, 8'd5};
      e33 = {8'd10, 8'd11, 8'd11, 8'd14, 8'd15, 8'd15, 8'd14, 8'd15, 8'd15};
`else
      e00 = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd4, 8'd5};
      e33 = {8'd10, 8'd11, 8'd0, 8'd14, 8'd15, 8'd0, 8'd0, 8'd0, 8'd0};
`endif
      e11 = {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10};
      clear_caps();
      nsrc = 16;
      for (int i = 0; i < 16; i++) src[i] = 8'(i);
      for (int i = 0; i < 200 && done_cnt == 0; i++) step(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
      checks++;
      if (done_cnt != 1) begin
         errors++;
         $display("FAIL str_done_cnt: got %0d want 1", done_cnt);
      end
      checks++;
      if (first_vcyc != acc6_cyc + 1 || acc6_cyc < 0) begin
         errors++;
         $display("FAIL str_first_valid: got cyc %0d want %0d",
                  first_vcyc, acc6_cyc + 1);
      end
      checks++;
      if (!seen16 || rdy_at16 !== 1'b0) begin
         errors++;
         $display("FAIL str_ready16: got %b want 0", rdy_at16);
      end
      checks++;
      if (cap_win.size() != 16) begin
         errors++;
         $display("FAIL str_count: got %0d want 16", cap_win.size());
      end else begin
         checks++;
         if (cap_win[0] !== e00) begin
            errors++;
            $display("FAIL str_w00: got %h want %h", cap_win[0], e00);
         end
         checks++;
         if (cap_win[5] !== e11) begin
            errors++;
            $display("FAIL str_w11: got %h want %h", cap_win[5], e11);
         end
         checks++;
         if (cap_win[15] !== e33) begin
            errors++;
            $display("FAIL str_w33: got %h want %h", cap_win[15], e33);
         end
         checks++;
         if (cap_row[15] != 3 || cap_col[15] != 3) begin
            errors++;
            $display("FAIL str_rc33: got %0d,%0d want 3,3",
                     cap_row[15], cap_col[15]);
         end
         checks++;
         if (cap_cyc[15] - cap_cyc[11] != 4) begin
            errors++;
            $display("FAIL str_flush_b2b: got span %0d want 4",
                     cap_cyc[15] - cap_cyc[11]);
         end
         checks++;
         if (done_cyc != cap_cyc[15] + 1) begin
            errors++;
            $display("FAIL str_done_cyc: got %0d want %0d",
                     done_cyc, cap_cyc[15] + 1);
         end
         for (int k = 0; k < 16; k++) begin
            checks++;
            if (cap_win[k] !== gold(0, k) ||
                cap_row[k] != k / W || cap_col[k] != k % W) begin
               errors++;
               $display("FAIL str_win%0d: got %h @%0d,%0d want %h",
                        k, cap_win[k], cap_row[k], cap_col[k], gold(0, k));
            end
         end
      end
   endtask

   task automatic test_stall();
      logic [71:0] e12;
      int stall;
      bit wr;
      e12 = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
      clear_caps();
      nsrc = 16;
      for (int i = 0; i < 16; i++) src[i] = 8'(i);
      stall = 0;
      for (int i = 0; i < 300 && done_cnt == 0; i++) begin
         wr = 1'b1;
         if (bus.o_win_valid && bus.o_row == 1 && bus.o_col == 2 &&
             stall < 10) begin
            wr = 1'b0;
            stall++;
            checks++;
            if (win_now() !== e12) begin
               errors++;
               $display("FAIL stl_hold: got %h want %h", win_now(), e12);
            end
            checks++;
            if (bus.o_in_ready !== 1'b0 || pix_idx != 12) begin
               errors++;
               $display("FAIL stl_ready: got rdy %b n_in %0d want 0 12",
                        bus.o_in_ready, pix_idx);
            end
         end
         step(1'b1, wr);
      end
      checks++;
      if (stall != 10 || done_cnt != 1) begin
         errors++;
         $display("FAIL stl_run: got stall %0d done %0d want 10 1",
                  stall, done_cnt);
      end
      checks++;
      if (cap_win.size() != 16) begin
         errors++;
         $display("FAIL stl_count: got %0d want 16", cap_win.size());
      end else begin
         for (int k = 0; k < 16; k++) begin
            checks++;
            if (cap_win[k] !== gold(0, k) ||
                cap_row[k] != k / W || cap_col[k] != k % W) begin
               errors++;
               $display("FAIL stl_win%0d: got %h want %h",
                        k, cap_win[k], gold(0, k));
            end
         end
      end
   endtask

   task automatic test_random_frames();
      clear_caps();
      nsrc = 32;
      for (int i = 0; i < 32; i++) src[i] = 8'($urandom_range(1, 255));
      for (int i = 0; i < 3000 && done_cnt < 2; i++)
         step($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
      checks++;
      if (done_cnt != 2) begin
         errors++;
         $display("FAIL rnd_done: got %0d want 2", done_cnt);
      end
      checks++;
      if (cap_win.size() != 32) begin
         errors++;
         $display("FAIL rnd_count: got %0d want 32", cap_win.size());
      end else begin
         for (int k = 0; k < 32; k++) begin
            checks++;
            if (cap_win[k] !== gold((k / 16) * 16, k % 16) ||
                cap_row[k] != (k % 16) / W || cap_col[k] != k % W) begin
               errors++;
               $display("FAIL rnd_win%0d: got %h want %h",
                        k, cap_win[k], gold((k / 16) * 16, k % 16));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      clear_caps();
      nsrc = 16;
      for (int i = 0; i < 16; i++) src[i] = 8'(i);
      for (int i = 0; i < 100 && pix_idx < 9; i++) step(1'b1, 1'b1);
      checks++;
      if (pix_idx != 9) begin
         errors++;
         $display("FAIL mid_fill: got %0d want 9", pix_idx);
      end
      bus.i_in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.o_win_valid !== 1'b0 || win_now() !== 72'd0) begin
         errors++;
         $display("FAIL mid_async: got v=%b w=%h want 0 0",
                  bus.o_win_valid, win_now());
      end
      checks++;
      if (bus.o_row !== '0 || bus.o_col !== '0) begin
         errors++;
         $display("FAIL mid_rc: got %0d,%0d want 0,0", bus.o_row, bus.o_col);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      checks++;
      if (bus.o_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_ready: got %b want 1", bus.o_in_ready);
      end
      test_stream();
   endtask

   initial begin
      nsrc = 0;
      clear_caps();
      test_reset();
      test_stream();
      test_stall();
      test_random_frames();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/window_gen_3x3.md
Name: window_gen_3x3

Overview:
Raster-scan pixel stream to 3x3 window generator, directly upstream of the 3x3 convolution datapath.
- Accepts one 8-bit pixel per handshake in row-major order.
- Buffers two image rows internally.
- Emits one 3x3 neighbourhood per output pixel, in raster order of centre position, with border padding.
- Output ports map one-to-one onto the convolution stage's p00..p22 inputs.

Parameters:
IMG_W, 64, image width in pixels (>=3)
IMG_H, 64, image height in pixels (>=3)

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_in_valid  input  1  upstream pixel valid
o_in_ready  output  1  block can accept pixel this cycle
i_pixel  input  8  unsigned pixel
o_win_valid  output  1  window outputs valid
i_win_ready  input  1  downstream accepts window
o_p00,o_p01,o_p02,o_p10,o_p11,o_p12,o_p20,o_p21,o_p22  output  8 each  window, row-major; o_p11 = centre
o_row  output  log2(IMG_H)  centre row of current window
o_col  output  log2(IMG_W)  centre column of current window
o_frame_done  output  1  one-cycle pulse after last window of frame accepted

Behaviour:
- Definitions: N = IMG_W*IMG_H. Input index i = r*IMG_W+c. Window k has centre (r,c), k = r*IMG_W+c.
- Counters: n_in counts pixels accepted, n_out counts windows accepted; both 0..N.
- Transfer rule: transfer when valid & ready on the same rising edge. Upstream/downstream may hold valid indefinitely; ready may toggle freely.
- Input ready (combinational): o_in_ready = (n_in < N) && (n_in < n_out + IMG_W + 2). This caps lookahead to 2 rows + 2 pixels of storage.
- Window enable: window k is emit-eligible when n_in >= min(N, k+IMG_W+2).
- o_win_valid is registered. It rises the cycle after eligibility is met, which is one cycle after the enabling pixel is accepted.
- Hold rule: while o_win_valid=1 and i_win_ready=0, all o_p*, o_row and o_col are held stable.
- Back-to-back: on acceptance, if window k+1 is already eligible, o_win_valid stays 1 and the data updates the next cycle. Sustained throughput is 1 window/cycle.
- Padding: any tap whose coordinate is outside [0,IMG_H-1]x[0,IMG_W-1] outputs 8'd0. Row and column wrap must never leak pixels from the adjacent row or column.
- Frame end: when n_out reaches N:
  - o_frame_done pulses for 1 cycle.
  - Both counters clear to 0 on the same edge.
  - The next pixel accepted is pixel (0,0) of a new frame. Line buffer contents need not be cleared, since padding masks stale data.
- Simultaneous accept: an input accept and an output accept in the same cycle are both honoured. Counters update independently.
- Reset (asynchronous, any time including mid-frame):
  - o_win_valid=0, o_frame_done=0, all o_p*=0, o_row=0, o_col=0.
  - n_in=n_out=0.
  - o_in_ready=1 in the first cycle after reset release.
  - A partial frame is discarded.
- Storage: two IMG_W x 8 line buffers (register arrays or single-port memories read/written once per accepted pixel) plus a 3x3 register window.
- States:
  - IDLE (n_in=0).
  - FILL (n_in < IMG_W+2).
  - RUN.
  - FLUSH (n_in=N, n_out<N; input blocked, windows drained with bottom padding).
  - FLUSH returns to IDLE on the last window accept.

Optional Feature:
- Macro: WINGEN_REPLICATE_PAD_EN.
- Defined: out-of-image taps take the nearest edge pixel (clamp coordinates to the image) instead of 0. Corner taps take the corner pixel.
- Undefined: zero padding as specified above.
- Handshake, latency and counters are identical in both builds.

Test Plan:
- IMG_W=IMG_H=4, pixel value = raster index 0..15, i_in_valid and i_win_ready held 1:
  - First o_win_valid occurs the cycle after the 6th accepted pixel.
  - Window (0,0) = 0,0,0,0,0,1,0,4,5.
  - o_in_ready drops to 0 after 16 pixels.
  - 16 windows are emitted in consecutive cycles, then o_frame_done pulses once.
- Same stimulus, interior window (1,1) = 0,1,2,4,5,6,8,9,10; last window (3,3) = 10,11,0,14,15,0,0,0,0 with o_row=3, o_col=3.
- i_win_ready=0 for 10 cycles during window (1,2):
  - Outputs are held stable (1,2,3,5,6,7,9,10,11).
  - o_in_ready falls once n_in = n_out+6.
  - Resuming delivers every window exactly once, with none skipped or duplicated.
- Randomly gapped i_in_valid and i_win_ready over two back-to-back frames: window sequences match the golden model, and frame 2 window (0,0) contains no frame-1 data.
- Assert i_rst_n low for 1 cycle mid-frame (after 9 pixels): outputs go 0 asynchronously; a fresh frame then reproduces scenario 1 exactly.
- With WINGEN_REPLICATE_PAD_EN defined, same stimulus as scenario 1: window (0,0) = 0,0,1,0,0,1,4,4,5 and window (3,3) = 10,11,11,14,15,15,14,15,15.
